alu_divider: RTL



---
 rtl/alu_pkg.sv | 27 ++
 rtl/div_step.sv | 24 ++
 rtl/alu_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/divider definitions for the execute stage.
package alu_pkg;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b100,
    AluMul = 3'b101,
    AluSlt = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } div_state_e;

  localparam int unsigned DIV_WIDTH   = 32;
  // Cycles from an accepted Start to the Done pulse, used by the hazard unit.
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 1;

  function automatic int unsigned div_latency(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit in, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_acc,
  input  logic [WIDTH-1:0] quo_acc,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_acc stays below the divisor and below 2^(step count), so its MSB is zero whenever
  // another step follows; the shifted value therefore fits in WIDTH+1 bits.
  always_comb begin
    shifted  = {rem_acc, quo_acc[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider beside the execute-stage ALU (DIV/DIVU).
// Optional signed support is enabled by defining DIV_SIGNED_EN.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
`ifdef DIV_SIGNED_EN
  input  logic             DivSigned,
`endif
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] quo_out;
  logic [WIDTH-1:0] rem_out;
  logic             accept;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_acc (rem_acc),
    .quo_acc (quo_acc),
    .divisor (divisor),
    .rem_next(rem_step),
    .quo_next(quo_step)
  );

  // Busy rises combinationally with an accepted Start so the stall lands in the request cycle.
  assign accept = ~RST & Start & (state != RUN);
  assign Busy   = (state == RUN) | accept;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_neg       = DivSigned & SrcA[WIDTH-1];
    b_neg       = DivSigned & SrcB[WIDTH-1];
    dividend_in = a_neg ? -SrcA : SrcA;
    divisor_in  = b_neg ? -SrcB : SrcB;
    quo_out     = neg_q ? -quo_step : quo_step;
    rem_out     = neg_r ? -rem_step : rem_step;
  end
`else
  always_comb begin
    dividend_in = SrcA;
    divisor_in  = SrcB;
    quo_out     = quo_step;
    rem_out     = rem_step;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_acc   <= '0;
      quo_acc   <= '0;
      divisor   <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        RUN: begin
          rem_acc <= rem_step;
          quo_acc <= quo_step;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= FINISH;
            Done      <= 1'b1;
            Quotient  <= quo_out;
            Remainder <= rem_out;
          end
        end
        default: begin
          if (accept) begin
            DivByZero <= 1'b0;
            if (SrcB == '0) begin
              // No iterations needed: the result is fixed and available on FINISH entry.
              state     <= FINISH;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= SrcA;
              DivByZero <= 1'b1;
            end else begin
              state   <= RUN;
              rem_acc <= '0;
              quo_acc <= dividend_in;
              divisor <= divisor_in;
              cnt     <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
